// File: rtl/mitch_arb_pkg.sv
// Shared constants and helpers for the MITCH multiplier arbiter.
package mitch_arb_pkg;

    localparam int OPW = 16;   // operand width
    localparam int PW  = 32;   // product width

    // Width of a requester index for n requesters (never less than one bit).
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mitch_core.sv
// Combinational Mitchell logarithmic 16x16 multiplier.
// A zero operand is seen by the leading-one detector as bit 0, so it behaves
// like an operand of 1; zero correction is handled by the caller.
module mitch_core
    import mitch_arb_pkg::*;
(
    input  logic [OPW-1:0] x,
    input  logic [OPW-1:0] y,
    output logic [PW-1:0]  p
);

    // Position of the most significant set bit (0 when v is zero).
    function automatic logic [3:0] lod16(input logic [15:0] v);
        logic [3:0] k;
        k = 4'd0;
        for (int i = 0; i < 16; i++) begin
            k = v[i] ? 4'(i) : k;
        end
        return k;
    endfunction

    logic [3:0]  kx_s;
    logic [3:0]  ky_s;
    logic [14:0] fx_s;
    logic [14:0] fy_s;
    logic [15:0] fsum_s;
    logic [4:0]  sh_s;

    // Log-domain add of characteristic and mantissa, then antilog by shifting.
    always_comb begin
        kx_s   = lod16(x);
        ky_s   = lod16(y);
        fx_s   = 15'(x << (4'd15 - kx_s));
        fy_s   = 15'(y << (4'd15 - ky_s));
        fsum_s = {1'b0, fx_s} + {1'b0, fy_s};
        // A mantissa carry bumps the characteristic; the remaining fraction
        // gets the implicit leading one back in both cases.
        sh_s   = {1'b0, kx_s} + {1'b0, ky_s} + {4'd0, fsum_s[15]};
        p      = PW'(({31'd0, 1'b1, fsum_s[14:0]} << sh_s) >> 5'd15);
    end

endmodule

// File: rtl/mitch_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NREQ. Grant is suppressed when en is low.
module mitch_rr_arb
    import mitch_arb_pkg::*;
#(
    parameter int NREQ = 4
)
(
    input  logic [NREQ-1:0]         req,
    input  logic [id_w(NREQ)-1:0]   ptr,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt,
    output logic [id_w(NREQ)-1:0]   idx,
    output logic                    any_req
);

    localparam int IDW = id_w(NREQ);

    logic [IDW-1:0] cand_s;

    // Rotating priority search starting at the pointer.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        any_req = 1'b0;
        cand_s  = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand_s = IDW'((int'(ptr) + off) % NREQ);
            if (!any_req && req[cand_s]) begin
                any_req = 1'b1;
                idx     = cand_s;
            end else begin
                any_req = any_req;
            end
        end
        if (en && any_req) begin
            gnt[idx] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/mitch_arbiter.sv
// Round-robin arbiter sharing one MITCH multiplier between NREQ clients
// through an operand stage (A) and a result stage (B) with valid/ready on
// both sides. Define MITCH_ARB_ZERO_BYPASS_EN to force a zero product when
// either operand is zero.
module mitch_arbiter
    import mitch_arb_pkg::*;
#(
    parameter int NREQ = 4
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*OPW-1:0]     req_x,
    input  logic [NREQ*OPW-1:0]     req_y,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [id_w(NREQ)-1:0]   resp_id,
    output logic [PW-1:0]           resp_p,
    output logic                    busy
);

    localparam int IDW = id_w(NREQ);

    logic [IDW-1:0] ptr_r;
    logic           a_vld_r;
    logic [OPW-1:0] a_x_r;
    logic [OPW-1:0] a_y_r;
    logic [IDW-1:0] a_id_r;
    logic           b_vld_r;
    logic [PW-1:0]  b_p_r;
    logic [IDW-1:0] b_id_r;

    logic           b_take_s;
    logic           b_free_s;
    logic           a_adv_s;
    logic           a_free_s;
    logic [NREQ-1:0] gnt_s;
    logic [IDW-1:0] win_s;
    logic           any_s;
    logic           acc_s;
    logic [OPW-1:0] sel_x_s;
    logic [OPW-1:0] sel_y_s;
    logic [IDW-1:0] ptr_nxt_s;
    logic [PW-1:0]  mitch_p_s;
    logic [PW-1:0]  b_load_s;

    // Pipeline handshake terms; ready is held low while reset is asserted.
    always_comb begin
        b_take_s = b_vld_r & resp_ready;
        b_free_s = ~b_vld_r | b_take_s;
        a_adv_s  = a_vld_r & b_free_s;
        a_free_s = ~a_vld_r | a_adv_s;
    end

    mitch_rr_arb #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_r),
        .en      (a_free_s & ~rst),
        .gnt     (gnt_s),
        .idx     (win_s),
        .any_req (any_s)
    );

    mitch_core u_core (
        .x (a_x_r),
        .y (a_y_r),
        .p (mitch_p_s)
    );

    // Accept decode, winner operand select and next pointer.
    always_comb begin
        acc_s     = any_s & (|(gnt_s & req_valid));
        sel_x_s   = req_x[int'(win_s)*OPW +: OPW];
        sel_y_s   = req_y[int'(win_s)*OPW +: OPW];
        if (win_s == IDW'(NREQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = win_s + IDW'(1);
        end
    end

    // Value captured into the result stage.
    always_comb begin
`ifdef MITCH_ARB_ZERO_BYPASS_EN
        if ((a_x_r == '0) || (a_y_r == '0)) begin
            b_load_s = '0;
        end else begin
            b_load_s = mitch_p_s;
        end
`else
        b_load_s = mitch_p_s;
`endif
    end

    // Stage A and round-robin pointer: load on accept, drain on advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r   <= '0;
            a_vld_r <= 1'b0;
            a_x_r   <= '0;
            a_y_r   <= '0;
            a_id_r  <= '0;
        end else if (acc_s) begin
            ptr_r   <= ptr_nxt_s;
            a_vld_r <= 1'b1;
            a_x_r   <= sel_x_s;
            a_y_r   <= sel_y_s;
            a_id_r  <= win_s;
        end else if (a_adv_s) begin
            a_vld_r <= 1'b0;
        end else begin
            a_vld_r <= a_vld_r;
        end
    end

    // Stage B: capture the product on advance, release on consumer take.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_vld_r <= 1'b0;
            b_p_r   <= '0;
            b_id_r  <= '0;
        end else if (a_adv_s) begin
            b_vld_r <= 1'b1;
            b_p_r   <= b_load_s;
            b_id_r  <= a_id_r;
        end else if (b_take_s) begin
            b_vld_r <= 1'b0;
        end else begin
            b_vld_r <= b_vld_r;
        end
    end

    assign req_ready  = gnt_s;
    assign resp_valid = b_vld_r;
    assign resp_p     = b_p_r;
    assign resp_id    = b_id_r;
    assign busy       = a_vld_r | b_vld_r;

endmodule
